// File: rtl/bytepipe_arb.sv
// bytepipe_arb: round-robin arbiter sharing one BytePipe link between N_REQ
// byte sources. It grants one source at a time for a burst of up to
// MAX_BURST bytes and then re-arbitrates, starting the search just after the
// last granted index.
//
// Optional feature: define BYTEPIPE_ARB_HEADER_EN to emit one header byte
// (HDR_TAG | grant index) before every burst.
//
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_cg             clock gate; low freezes state and blocks transfers
//   i_bpReq_data     requester data, requester k at [8k+7:8k]
//   i_bpReq_valid    requester valid
//   o_bpReq_ready    requester ready, at most one bit set
//   o_bp_data        shared link data
//   o_bp_valid       shared link valid
//   i_bp_ready       shared link ready
//   o_grant          one-hot current grant, 0 when idle
//   o_busy           arbiter is not idle
module bytepipe_arb #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned MAX_BURST = 16,
    parameter logic [7:0]  HDR_TAG   = 8'hA0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cg,
    input  logic [8*N_REQ-1:0]   i_bpReq_data,
    input  logic [N_REQ-1:0]     i_bpReq_valid,
    output logic [N_REQ-1:0]     o_bpReq_ready,
    output logic [7:0]           o_bp_data,
    output logic                 o_bp_valid,
    input  logic                 i_bp_ready,
    output logic [N_REQ-1:0]     o_grant,
    output logic                 o_busy
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = 9;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_BURST  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   grant_idx, grant_idx_nxt;
    logic [IDX_W-1:0]   last_idx, last_idx_nxt;
    logic [CNT_W-1:0]   count, count_nxt;
    logic [N_REQ-1:0]   grant, grant_nxt;

    logic               req_any;
    logic [IDX_W-1:0]   pick_idx;
    logic [7:0]         sel_data;
    logic               sel_valid;
    logic [7:0]         bp_data;
    logic               bp_valid;
    logic [N_REQ-1:0]   req_ready;
    logic               xfer;

    // Round-robin pick: walk offsets from far to near so the nearest valid
    // index after last_idx is the one left standing.
    always_comb begin
        req_any  = 1'b0;
        pick_idx = last_idx;
        for (int i = N_REQ; i >= 1; i--) begin
            if (i_bpReq_valid[IDX_W'((32'(last_idx) + 32'(i)) % N_REQ)]) begin
                req_any  = 1'b1;
                pick_idx = IDX_W'((32'(last_idx) + 32'(i)) % N_REQ);
            end
        end
    end

    // Mux the granted source onto the link.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_idx == IDX_W'(k)) begin
                sel_data  = i_bpReq_data[8*k +: 8];
                sel_valid = i_bpReq_valid[k];
            end
        end
    end

    // Next-state and link outputs.
    always_comb begin
        state_nxt     = state;
        grant_idx_nxt = grant_idx;
        last_idx_nxt  = last_idx;
        count_nxt     = count;
        grant_nxt     = grant;
        bp_data       = '0;
        bp_valid      = 1'b0;
        req_ready     = '0;
        xfer          = 1'b0;

        case (state)
            ST_IDLE: begin
                if (i_cg && req_any) begin
                    grant_idx_nxt = pick_idx;
                    last_idx_nxt  = pick_idx;
                    count_nxt     = '0;
                    grant_nxt     = N_REQ'(1) << pick_idx;
`ifdef BYTEPIPE_ARB_HEADER_EN
                    state_nxt     = ST_HEADER;
`else
                    state_nxt     = ST_BURST;
`endif
                end
            end

            ST_HEADER: begin
                bp_data  = HDR_TAG | {5'd0, 3'(grant_idx)};
                bp_valid = i_cg;
                if (i_cg && i_bp_ready) begin
                    state_nxt = ST_BURST;
                end
            end

            ST_BURST: begin
                bp_data  = sel_data;
                bp_valid = sel_valid & i_cg;
                if (i_cg) begin
                    req_ready = N_REQ'(i_bp_ready) << grant_idx;
                end
                xfer = bp_valid & i_bp_ready;
                if (i_cg) begin
                    // A source gap ends the burst so others get a turn.
                    if (!sel_valid) begin
                        state_nxt = ST_IDLE;
                        grant_nxt = '0;
                    end else if (xfer) begin
                        count_nxt = count + CNT_W'(1);
                        if (count == CNT_LAST) begin
                            state_nxt = ST_IDLE;
                            grant_nxt = '0;
                        end
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // State register; last_idx starts at N_REQ-1 so requester 0 wins first.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            grant_idx <= '0;
            last_idx  <= IDX_W'(N_REQ - 1);
            count     <= '0;
            grant     <= '0;
        end else begin
            state     <= state_nxt;
            grant_idx <= grant_idx_nxt;
            last_idx  <= last_idx_nxt;
            count     <= count_nxt;
            grant     <= grant_nxt;
        end
    end

    // Outputs are forced low while reset is held.
    assign o_bp_data     = i_rst ? 8'd0 : bp_data;
    assign o_bp_valid    = ~i_rst & bp_valid;
    assign o_bpReq_ready = i_rst ? '0 : req_ready;
    assign o_grant       = i_rst ? '0 : grant;
    assign o_busy        = ~i_rst & (state != ST_IDLE);

endmodule

// File: tb/tb_bytepipe_arb.sv
// Directed testbench for bytepipe_arb (N_REQ=4, MAX_BURST=16, HDR_TAG=A0).
module tb_bytepipe_arb;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_cg;
    logic [31:0] req_data;
    logic [3:0]  req_valid;
    logic [3:0]  o_bpReq_ready;
    logic [7:0]  o_bp_data;
    logic        o_bp_valid;
    logic        i_bp_ready;
    logic [3:0]  o_grant;
    logic        o_busy;

    // Source model: remain = bytes left (-1 means endless), nbyte = next byte.
    int          remain [4];
    logic [7:0]  nbyte  [4];
    int          n_checks = 0;
    int          n_fail   = 0;

    bytepipe_arb #(.N_REQ(4), .MAX_BURST(16), .HDR_TAG(8'hA0)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_cg          (i_cg),
        .i_bpReq_data  (req_data),
        .i_bpReq_valid (req_valid),
        .o_bpReq_ready (o_bpReq_ready),
        .o_bp_data     (o_bp_data),
        .o_bp_valid    (o_bp_valid),
        .i_bp_ready    (i_bp_ready),
        .o_grant       (o_grant),
        .o_busy        (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_link(input string tag, input logic v, input logic [7:0] d,
                              input logic [3:0] rdy, input logic [3:0] g);
        chk({tag, " valid"}, 16'(o_bp_valid), 16'(v));
        chk({tag, " data"},  16'(o_bp_data), 16'(d));
        chk({tag, " ready"}, 16'(o_bpReq_ready), 16'(rdy));
        chk({tag, " grant"}, 16'(o_grant), 16'(g));
    endtask

    // Drive source outputs from the model and let combinational logic settle.
    task automatic settle();
        for (int k = 0; k < 4; k++) begin
            req_valid[k]       = (remain[k] != 0);
            req_data[8*k +: 8] = nbyte[k];
        end
        #1;
    endtask

    // Clock one edge and retire any bytes the sources handed over.
    task automatic advance();
        logic [3:0] took;
        took = o_bpReq_ready & req_valid;
        @(posedge i_clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (took[k]) begin
                nbyte[k] = nbyte[k] + 8'd1;
                if (remain[k] > 0) remain[k]--;
            end
        end
    endtask

    task automatic quiet_reset();
        for (int k = 0; k < 4; k++) remain[k] = 0;
        i_rst = 1'b1;
        settle();
        advance();
        i_rst = 1'b0;
    endtask

    initial begin
        logic       bp_pat [4];
        logic [7:0] d_pat  [4];
        logic [3:0] r_pat  [4];
        int         k;

        i_cg       = 1'b1;
        i_bp_ready = 1'b1;
        i_rst      = 1'b1;
        for (int j = 0; j < 4; j++) begin
            remain[j] = -1;
            nbyte[j]  = 8'(j * 64);
        end

        // Reset held two cycles with every source valid.
        for (int c = 0; c < 2; c++) begin
            settle();
            check_link("reset", 1'b0, 8'h00, 4'b0000, 4'b0000);
            chk("reset busy", 16'(o_busy), 16'd0);
            advance();
        end
        for (int j = 0; j < 4; j++) remain[j] = 0;
        i_rst = 1'b0;

`ifdef BYTEPIPE_ARB_HEADER_EN
        // Header then payload; header held while the link stalls.
        remain[3]  = 1;
        nbyte[3]   = 8'h55;
        i_bp_ready = 1'b0;
        settle();
        chk("hdr idle busy", 16'(o_busy), 16'd0);
        advance();
        settle();
        check_link("hdr", 1'b1, 8'hA3, 4'b0000, 4'b1000);
        advance();
        settle();
        check_link("hdr_hold", 1'b1, 8'hA3, 4'b0000, 4'b1000);
        i_bp_ready = 1'b1;
        settle();
        check_link("hdr_take", 1'b1, 8'hA3, 4'b0000, 4'b1000);
        advance();
        settle();
        check_link("hdr_pay", 1'b1, 8'h55, 4'b1000, 4'b1000);
        advance();
        settle();
        chk("hdr_end valid", 16'(o_bp_valid), 16'd0);
        advance();
        settle();
        chk("hdr_end busy", 16'(o_busy), 16'd0);
`else
        // Single source: req2 sends 10..13.
        remain[2] = 4;
        nbyte[2]  = 8'h10;
        settle();
        chk("single idle valid", 16'(o_bp_valid), 16'd0);
        chk("single idle grant", 16'(o_grant), 16'd0);
        advance();
        for (int i = 0; i < 4; i++) begin
            settle();
            check_link("single", 1'b1, 8'(8'h10 + i), 4'b0100, 4'b0100);
            chk("single busy", 16'(o_busy), 16'd1);
            advance();
        end
        settle();
        chk("single gap valid", 16'(o_bp_valid), 16'd0);
        advance();
        settle();
        chk("single end busy", 16'(o_busy), 16'd0);
        chk("single end grant", 16'(o_grant), 16'd0);

        // Fairness: all four endlessly valid, 16-byte bursts in rotation.
        quiet_reset();
        for (int j = 0; j < 4; j++) begin
            remain[j] = -1;
            nbyte[j]  = 8'(j * 64);
        end
        settle();
        chk("fair idle busy", 16'(o_busy), 16'd0);
        advance();
        for (int b = 0; b < 5; b++) begin
            k = b % 4;
            for (int i = 0; i < 16; i++) begin
                settle();
                check_link("fair", 1'b1, 8'(k * 64 + (b / 4) * 16 + i),
                           4'(1 << k), 4'(1 << k));
                advance();
            end
            settle();
            chk("fair gap valid", 16'(o_bp_valid), 16'd0);
            chk("fair gap busy", 16'(o_busy), 16'd0);
            advance();
        end

        // Backpressure on req1, a clock-gate stall, and burst length by transfers.
        quiet_reset();
        remain[1] = -1;
        nbyte[1]  = 8'h20;
        i_bp_ready = 1'b1;
        settle();
        advance();
        bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        d_pat  = '{8'h20, 8'h21, 8'h21, 8'h21};
        r_pat  = '{4'b0010, 4'b0000, 4'b0000, 4'b0010};
        for (int i = 0; i < 4; i++) begin
            i_bp_ready = bp_pat[i];
            settle();
            check_link("bp", 1'b1, d_pat[i], r_pat[i], 4'b0010);
            advance();
        end
        i_bp_ready = 1'b1;
        i_cg = 1'b0;
        settle();
        chk("cg valid", 16'(o_bp_valid), 16'd0);
        chk("cg ready", 16'(o_bpReq_ready), 16'd0);
        chk("cg grant", 16'(o_grant), 16'b0010);
        advance();
        i_cg = 1'b1;
        for (int i = 0; i < 14; i++) begin
            settle();
            check_link("bp_rest", 1'b1, 8'(8'h22 + i), 4'b0010, 4'b0010);
            advance();
        end
        settle();
        chk("bp_end valid", 16'(o_bp_valid), 16'd0);
        chk("bp_end busy", 16'(o_busy), 16'd0);

        // Source gap hands over to req3; then reset mid-burst.
        quiet_reset();
        remain[0] = 3;
        nbyte[0]  = 8'h70;
        remain[3] = 2;
        nbyte[3]  = 8'h90;
        settle();
        advance();
        for (int i = 0; i < 3; i++) begin
            settle();
            check_link("gap", 1'b1, 8'(8'h70 + i), 4'b0001, 4'b0001);
            advance();
        end
        settle();
        chk("gap end valid", 16'(o_bp_valid), 16'd0);
        advance();
        settle();
        chk("gap idle busy", 16'(o_busy), 16'd0);
        advance();
        settle();
        check_link("gap next", 1'b1, 8'h90, 4'b1000, 4'b1000);
        advance();
        settle();
        chk("gap next data", 16'(o_bp_data), 16'h0091);
        i_rst     = 1'b1;
        remain[0] = -1;
        nbyte[0]  = 8'h80;
        settle();
        chk("midrst valid", 16'(o_bp_valid), 16'd0);
        chk("midrst ready", 16'(o_bpReq_ready), 16'd0);
        advance();
        i_rst = 1'b0;
        settle();
        chk("postrst busy", 16'(o_busy), 16'd0);
        chk("postrst grant", 16'(o_grant), 16'd0);
        advance();
        settle();
        check_link("postrst", 1'b1, 8'h80, 4'b0001, 4'b0001);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
